imem_boot_ctrl: RTL and testbench

//  Boot loader / sequencer for the IF-stage instruction memory.
//  - Accepts a byte stream over a valid/ready handshake and packs it into 32-bit words.
//  - Drives the IF write port (WE, W_Ins), one word per write, at incrementing word-aligned addresses.
//  - Holds the CPU (PC) in reset for the whole load, then releases it.
//  - Sits between the host/UART receive path and the IF stage.

---
 rtl/imem_boot_ctrl.sv | 163 ++++++++++++++++
 tb/tb_imem_boot_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: boot loader that packs a byte stream into 32-bit words and writes them to IMem
//
// Receives bytes over a valid/ready handshake, assembles them big-endian into
// words and writes each word to the IF-stage instruction memory at consecutive
// word-aligned byte addresses. The CPU is held in reset for the whole load.
//
// Optional feature: define IMEM_BOOT_CKSUM_EN to require a trailing 32-bit
// checksum (sum of all written words, mod 2^32) after the last word.
//
// Ports
//   CLK, RST    clock (rising edge), synchronous active-high reset
//   start       1-cycle load request, sampled in IDLE only
//   len         number of words to load, sampled with start
//   rx_data     stream byte
//   rx_valid    rx_data valid
//   rx_ready    byte accepted this cycle
//   imem_we     IMem write enable
//   imem_addr   word-aligned byte address of the write
//   imem_wdata  write word
//   cpu_hold    holds the CPU/PC in reset
//   busy        a load is in progress
//   done        1-cycle pulse at end of load
//   err         1-cycle pulse with done on failure
module imem_boot_ctrl #(
   parameter int IMEM_SIZE = 256,
   parameter int ADDR_W    = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   input  logic [ADDR_W:0]   len,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [31:0]       imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err
);
`ifdef IMEM_BOOT_CKSUM_EN
   typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, FIN} state_t;
`else
   typedef enum logic [1:0] {IDLE, RECV, WRITE, FIN} state_t;
`endif
   localparam logic [ADDR_W:0] SIZE_L = IMEM_SIZE[ADDR_W:0];
   state_t            state_q, state_d;
   logic [ADDR_W:0]   len_q, len_d, cnt_q, cnt_d;
   logic [1:0]        bidx_q, bidx_d;
   logic [31:0]       word_q, word_d;
   logic              busy_q, busy_d, hold_q, hold_d, err_q, err_d;
`ifdef IMEM_BOOT_CKSUM_EN
   logic [31:0]       sum_q, sum_d;
`endif
   assign busy     = busy_q;
   assign cpu_hold = hold_q;
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         bidx_q  <= '0;
         word_q  <= '0;
         busy_q  <= 1'b0;
         hold_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef IMEM_BOOT_CKSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         bidx_q  <= bidx_d;
         word_q  <= word_d;
         busy_q  <= busy_d;
         hold_q  <= hold_d;
         err_q   <= err_d;
`ifdef IMEM_BOOT_CKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      bidx_d     = bidx_q;
      word_d     = word_q;
      busy_d     = busy_q;
      hold_d     = hold_q;
      err_d      = err_q;
`ifdef IMEM_BOOT_CKSUM_EN
      sum_d      = sum_q;
`endif
      rx_ready   = 1'b0;
      imem_we    = 1'b0;
      imem_addr  = '0;
      imem_wdata = '0;
      done       = 1'b0;
      err        = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            busy_d  = 1'b1;
            hold_d  = 1'b1;
            len_d   = len;
            cnt_d   = '0;
            bidx_d  = '0;
            word_d  = '0;
            err_d   = len > SIZE_L;
`ifdef IMEM_BOOT_CKSUM_EN
            sum_d   = '0;
`endif
            state_d = (len == '0 || len > SIZE_L) ? FIN : RECV;
         end
         RECV: begin
            rx_ready = 1'b1;
            if (rx_valid) begin
               // shifting left puts the first byte of the word in [31:24]
               word_d  = {word_q[23:0], rx_data};
               bidx_d  = bidx_q + 2'd1;
               state_d = (bidx_q == 2'd3) ? WRITE : RECV;
            end
         end
         WRITE: begin
            imem_we    = 1'b1;
            imem_addr  = {{(30-ADDR_W){1'b0}}, cnt_q[ADDR_W-1:0], 2'b00};
            imem_wdata = word_q;
            cnt_d      = cnt_q + 1'b1;
`ifdef IMEM_BOOT_CKSUM_EN
            sum_d      = sum_q + word_q;
            state_d    = (cnt_q + 1'b1 == len_q) ? CHECK : RECV;
`else
            state_d    = (cnt_q + 1'b1 == len_q) ? FIN : RECV;
`endif
         end
`ifdef IMEM_BOOT_CKSUM_EN
         CHECK: begin
            rx_ready = 1'b1;
            if (rx_valid) begin
               word_d = {word_q[23:0], rx_data};
               bidx_d = bidx_q + 2'd1;
               if (bidx_q == 2'd3) begin
                  err_d   = {word_q[23:0], rx_data} != sum_q;
                  state_d = FIN;
               end
            end
         end
`endif
         FIN: begin
            done    = 1'b1;
            err     = err_q;
            busy_d  = 1'b0;
            // a failed load keeps the CPU parked until a good load or RST
            hold_d  = err_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb_imem_boot_ctrl: self-checking bench for imem_boot_ctrl
module tb_imem_boot_ctrl;
   localparam int IMEM_SIZE = 256;
   localparam int ADDR_W    = 8;
   logic CLK = 1'b0, RST = 1'b1, start = 1'b0, rx_valid = 1'b0;
   logic [ADDR_W:0] len = '0;
   logic [7:0] rx_data = '0;
   logic rx_ready, imem_we, cpu_hold, busy, done, err;
   logic [31:0] imem_addr, imem_wdata;
   int vectors = 0, miscompares = 0;
   logic [31:0] wq_a[$], wq_d[$], wds[$];
   logic [7:0] tx_q[$];

   imem_boot_ctrl #(.IMEM_SIZE(IMEM_SIZE), .ADDR_W(ADDR_W)) dut (
      .CLK(CLK), .RST(RST), .start(start), .len(len), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
      .busy(busy), .done(done), .err(err));

   always #5 CLK = ~CLK;

   always @(negedge CLK) if (imem_we) begin
      wq_a.push_back(imem_addr);
      wq_d.push_back(imem_wdata);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // mode 0: random rx_valid, 1: toggling, 2: always valid
   task automatic feed(input int mode, input bit inject);
      int idx = 0;
      bit acc;
      for (int g = 0; g < 8000 && idx < tx_q.size(); g++) begin
         rx_valid = (mode == 2) ? 1'b1 : (mode == 1) ? (g % 2 == 0) : ($urandom_range(0, 3) != 0);
         rx_data  = rx_valid ? tx_q[idx] : 8'($urandom);
         start    = inject && g == 5;
         if (start) len = 9'd3;
         @(negedge CLK);
         acc = rx_valid && rx_ready;
         @(posedge CLK); #1;
         if (acc) idx++;
      end
      rx_valid = 1'b0;
      start    = 1'b0;
      chk("bytes_accepted", idx, tx_q.size());
   endtask

   task automatic run_load(input int mode, input bit inject, input logic [31:0] ck_xor);
      logic [31:0] sum = '0;
      bit seen = 1'b0;
      bit exp_err = ck_xor != 0;
      int n = wds.size();
      wq_a.delete(); wq_d.delete(); tx_q.delete();
      foreach (wds[i]) begin
         sum += wds[i];
         for (int b = 3; b >= 0; b--) tx_q.push_back(wds[i][8*b +: 8]);
      end
`ifdef IMEM_BOOT_CKSUM_EN
      sum ^= ck_xor;
      for (int b = 3; b >= 0; b--) tx_q.push_back(sum[8*b +: 8]);
`else
      exp_err = 1'b0;
`endif
      start = 1'b1;
      len   = n[ADDR_W:0];
      @(posedge CLK); #1;
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("hold_after_start", cpu_hold, 1);
      feed(mode, inject);
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge CLK);
         seen = done;
      end
      chk("done_seen", seen, 1);
      chk("err_with_done", err, exp_err);
      @(negedge CLK);
      chk("done_width", done, 0);
      chk("busy_after_fin", busy, 0);
      chk("hold_after_fin", cpu_hold, exp_err);
      chk("write_count", wq_a.size(), n);
      foreach (wq_a[i]) if (i < n) begin
         chk("write_addr", wq_a[i], 32'(i * 4));
         chk("write_data", wq_d[i], wds[i]);
      end
      @(posedge CLK); #1;
   endtask

   task automatic short_load(input int n, input bit exp_err);
      wq_a.delete();
      start = 1'b1;
      len   = n[ADDR_W:0];
      @(posedge CLK); #1;
      start = 1'b0;
      @(negedge CLK);
      chk("short_done", done, 1);
      chk("short_err", err, exp_err);
      chk("short_busy", busy, 1);
      @(negedge CLK);
      chk("short_done_width", done, 0);
      chk("short_busy_after", busy, 0);
      chk("short_hold_after", cpu_hold, exp_err);
      chk("short_no_writes", wq_a.size(), 0);
      @(posedge CLK); #1;
   endtask

   initial begin
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_rx_ready", rx_ready, 0);
      chk("rst_we", imem_we, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_wdata", imem_wdata, 0);
      chk("rst_hold", cpu_hold, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      RST = 1'b0;
      @(posedge CLK); #1;
      // T1 two words, rx_valid always high
      wds = '{32'h00112233, 32'h44556677};
      run_load(2, 1'b0, 32'h0);
      // T2 one word, rx_valid toggling
      wds = '{32'hDEADBEEF};
      run_load(1, 1'b0, 32'h0);
      // T3 zero length and oversize length
      short_load(0, 1'b0);
      short_load(IMEM_SIZE + 1, 1'b1);
      // T4 RST after two bytes of the first word
      wq_a.delete();
      start = 1'b1;
      len   = 9'd1;
      @(posedge CLK); #1;
      start = 1'b0;
      tx_q  = '{8'hAA, 8'hBB};
      feed(2, 1'b0);
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      chk("midrst_busy", busy, 0);
      chk("midrst_hold", cpu_hold, 0);
      chk("midrst_we", imem_we, 0);
      chk("midrst_rx_ready", rx_ready, 0);
      chk("midrst_no_writes", wq_a.size(), 0);
      @(posedge CLK); #1;
      wds = '{32'hCAFEF00D};
      run_load(2, 1'b0, 32'h0);
      // T5 start pulsed mid-load with a different len
      wds.delete();
      repeat (4) wds.push_back($urandom);
      run_load(0, 1'b1, 32'h0);
      // random loads
      repeat (5) begin
         wds.delete();
         repeat ($urandom_range(1, 7)) wds.push_back($urandom);
         run_load(0, 1'b0, 32'h0);
      end
      // full memory: last address is 0x3FC
      wds.delete();
      repeat (IMEM_SIZE) wds.push_back($urandom);
      run_load(2, 1'b0, 32'h0);
`ifdef IMEM_BOOT_CKSUM_EN
      // T6 checksum match then mismatch, then a good load releases the CPU
      wds = '{32'h00000001, 32'hFFFFFFFF};
      run_load(2, 1'b0, 32'h0);
      run_load(2, 1'b0, 32'h1);
      wds = '{32'h12345678};
      run_load(0, 1'b0, 32'h0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
